// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order with a ping-pong double buffer.
// Latency: output index 0 appears two clocks after the last sample of a frame is accepted.
module fft_bitrev_reorder #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic             on,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_last
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [0:1][0:N-1];

  logic [AW-1:0]      wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic [1:0]         full_q, full_d, full_set, full_clr;
  logic               wr_acc;

  state_t             state_q, state_d;
  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               rd_bank_q, rd_bank_d;
  logic               rd_fire, rd_last;

  logic [2*WIDTH-1:0] rd_dat_q;
  logic               rd_vld_q, rd_last_q;
  logic               do_en_q, do_last_q;
  logic [WIDTH-1:0]   do_re_q, do_im_q;

  assign wr_acc = di_en & on;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    if (!on) begin
      wr_cnt_d = '0;
    end else if (di_en) begin
      if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d            = '0;
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // IDLE issues address 0 in the same cycle it sees a full bank, so a frame
  // reaches the output two clocks after its last write and back-to-back
  // frames leave no bubble when the read side falls through IDLE.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_clr  = 2'b00;
    rd_fire   = 1'b0;
    rd_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_fire = 1'b1;
          state_d = READ;
        end
      end
      READ: rd_fire = 1'b1;
      default: state_d = IDLE;
    endcase
    if (rd_fire) begin
      if (rd_cnt_q == LAST_IDX) begin
        rd_last             = 1'b1;
        rd_cnt_d            = '0;
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        state_d             = full_q[~rd_bank_q] ? READ : IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  assign full_d = (full_q & ~full_clr) | full_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      do_en_q   <= 1'b0;
      do_last_q <= 1'b0;
      do_re_q   <= '0;
      do_im_q   <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_vld_q  <= rd_fire;
      rd_last_q <= rd_last;
      do_en_q   <= rd_vld_q;
      do_last_q <= rd_vld_q & rd_last_q;
      if (rd_vld_q) begin
        do_re_q <= rd_dat_q[2*WIDTH-1:WIDTH];
        do_im_q <= rd_dat_q[WIDTH-1:0];
      end
    end
  end

  // Sample storage and the read data register carry no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_bank_q][bitrev(wr_cnt_q)] <= {di_re, di_im};
    if (rd_fire) rd_dat_q <= mem[rd_bank_q][rd_cnt_q];
  end

  assign do_en   = do_en_q;
  assign do_last = do_last_q;
  assign do_re   = do_re_q;
  assign do_im   = do_im_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: three instances (N=8, 128, 64) share a clock and
// reset; only the selected one receives samples, and its output is scoreboarded.
module tb_fft_bitrev_reorder;

  logic        clk;
  logic        rst;
  logic        on;
  logic        di_en;
  logic [15:0] di_re, di_im;
  int          sel;

  logic        en8, en64, en128;
  logic        do_en8, do_en64, do_en128;
  logic        do_last8, do_last64, do_last128;
  logic [15:0] do_re8, do_re64, do_re128;
  logic [15:0] do_im8, do_im64, do_im128;

  logic        do_en_m, do_last_m;
  logic [15:0] do_re_m, do_im_m;

  int passed = 0;
  int total  = 0;
  int out_cnt = 0;
  int en_cnt  = 0;
  int run     = 0;
  int maxrun  = 0;
  logic [32:0] exp_q [$];

  assign en8   = di_en & (sel == 8);
  assign en64  = di_en & (sel == 64);
  assign en128 = di_en & (sel == 128);

  fft_bitrev_reorder #(.N(8), .WIDTH(16)) u8 (
    .clk(clk), .rst(rst), .di_en(en8), .di_re(di_re), .di_im(di_im), .on(on),
    .do_en(do_en8), .do_re(do_re8), .do_im(do_im8), .do_last(do_last8));
  fft_bitrev_reorder #(.N(64), .WIDTH(16)) u64 (
    .clk(clk), .rst(rst), .di_en(en64), .di_re(di_re), .di_im(di_im), .on(on),
    .do_en(do_en64), .do_re(do_re64), .do_im(do_im64), .do_last(do_last64));
  fft_bitrev_reorder #(.N(128), .WIDTH(16)) u128 (
    .clk(clk), .rst(rst), .di_en(en128), .di_re(di_re), .di_im(di_im), .on(on),
    .do_en(do_en128), .do_re(do_re128), .do_im(do_im128), .do_last(do_last128));

  always_comb begin
    case (sel)
      8: begin
        do_en_m = do_en8; do_last_m = do_last8; do_re_m = do_re8; do_im_m = do_im8;
      end
      64: begin
        do_en_m = do_en64; do_last_m = do_last64; do_re_m = do_re64; do_im_m = do_im64;
      end
      default: begin
        do_en_m = do_en128; do_last_m = do_last128; do_re_m = do_re128; do_im_m = do_im128;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int brev(input int x, input int n);
    int bits = $clog2(n);
    int r = 0;
    for (int b = 0; b < bits; b++) r |= ((x >> b) & 1) << (bits - 1 - b);
    return r;
  endfunction

  always @(negedge clk) begin
    if (do_en_m) begin
      en_cnt++;
      run++;
      if (run > maxrun) maxrun = run;
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(do_en_m), 64'd0);
      end else begin
        check("out_sample", 64'({do_last_m, do_re_m, do_im_m}), 64'(exp_q.pop_front()));
        out_cnt++;
      end
    end else begin
      run = 0;
    end
  end

  // Drives cnt samples into an n-point instance; pushes expectations only for a complete frame.
  task automatic send_frame(input int n, input int cnt, input int base, input int gapmode);
    logic [15:0] vals [$];
    logic [15:0] v;
    int g;
    for (int i = 0; i < cnt; i++) begin
      g = 0;
      if (gapmode == 1 && i > 0) g = 1;
      if (gapmode == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 2);
      repeat (g) begin
        di_en = 1'b0;
        @(posedge clk); #1;
      end
      v = 16'(base + i);
      di_en = 1'b1;
      di_re = v;
      di_im = ~v;
      vals.push_back(v);
      @(posedge clk); #1;
    end
    di_en = 1'b0;
    if (cnt == n) begin
      for (int j = 0; j < n; j++) begin
        v = vals[brev(j, n)];
        exp_q.push_back({(j == n - 1), v, ~v});
      end
    end
  endtask

  task automatic lat_check();
    @(posedge clk); #1;
    check("lat_k1_idle", 64'(do_en_m), 64'd0);
    @(posedge clk); #1;
    check("lat_k2_valid", 64'(do_en_m), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; on = 1'b1; di_en = 1'b0; di_re = '0; di_im = '0; sel = 8;
    repeat (3) @(posedge clk);
    #1;
    check("rst_do_en", 64'(do_en_m), 64'd0);
    check("rst_do_last", 64'(do_last_m), 64'd0);
    check("rst_do_re", 64'(do_re_m), 64'd0);
    check("rst_do_im", 64'(do_im_m), 64'd0);
    check("rst_do_en64", 64'(do_en64), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single N=8 frame
    send_frame(8, 8, 0, 0);
    lat_check();
    wait_drain();
    check("hold_re", 64'(do_re_m), 64'h7);
    check("hold_im", 64'(do_im_m), 64'hfff8);
    check("idle_en", 64'(do_en_m), 64'd0);

    // gapped input
    send_frame(8, 8, 16, 1);
    lat_check();
    wait_drain();

    // partial frame discarded by on=0
    send_frame(8, 5, 32, 0);
    on = 1'b0;
    @(posedge clk); #1;
    on = 1'b1;
    send_frame(8, 8, 48, 0);
    lat_check();
    wait_drain();

    // reset during readout, after four outputs
    out_cnt = 0;
    send_frame(8, 8, 64, 0);
    lat_check();
    repeat (3) @(posedge clk);
    #7;
    check("pre_rst_outs", 64'(out_cnt), 64'd4);
    check("pre_rst_en", 64'(do_en_m), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_do_en", 64'(do_en_m), 64'd0);
    check("arst_do_last", 64'(do_last_m), 64'd0);
    check("arst_do_re", 64'(do_re_m), 64'd0);
    check("arst_do_im", 64'(do_im_m), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(8, 8, 80, 0);
    lat_check();
    wait_drain();

    // three back-to-back N=128 frames
    sel = 128;
    maxrun = 0;
    en_cnt = 0;
    send_frame(128, 128, 0, 0);
    send_frame(128, 128, 1000, 0);
    send_frame(128, 128, 2000, 0);
    wait_drain();
    check("b2b_run", 64'(maxrun), 64'd384);
    check("b2b_count", 64'(en_cnt), 64'd384);

    // random soak, N=64
    sel = 64;
    en_cnt = 0;
    for (int f = 0; f < 200; f++) send_frame(64, 64, f * 64, 2);
    wait_drain();
    check("soak_count", 64'(en_cnt), 64'(64 * 200));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
